// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronizes, debounces and edge-detects four raw board
//                pushbuttons. Emits one single-cycle pulse per accepted
//                press. Coin presses are serialized, with priority
//                note10 > note5 > note2, so at most one coin pulse is high
//                per cycle and no press is lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnl_raw,
    input  logic       btnr_raw,
    input  logic       btnd_raw,
    input  logic       btnc_raw,
    output logic       note2,
    output logic       note5,
    output logic       note10,
    output logic       withdraw,
    output logic [3:0] btn_level,
    output logic       coin_busy
);

    // Counter value at which a disagreeing input is finally accepted.
    localparam logic [CNT_W-1:0] C_CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button order everywhere: bit 3 = C, 2 = D, 1 = R, 0 = L.
    logic [3:0] raw_w;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] press_w;
    logic [3:0] level_w;

    // Coin pending bits: bit 2 = note10, bit 1 = note5, bit 0 = note2.
    logic [2:0] pend_q, pend_d;
    logic       note2_q, note2_d;
    logic       note5_q, note5_d;
    logic       note10_q, note10_d;
    logic       withdraw_q, withdraw_d;
    logic       coin_busy_q, coin_busy_d;

    assign raw_w = {btnc_raw, btnd_raw, btnr_raw, btnl_raw};

    // Two-stage synchronizer next-state.
    always_comb begin
        sync1_d = raw_w;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             lvl_q, lvl_d;
            logic             press_evt;

            // Level flips only after a full run of disagreeing samples;
            // a rising flip is the press event.
            always_comb begin
                cnt_d     = cnt_q;
                lvl_d     = lvl_q;
                press_evt = 1'b0;
                if (sync2_q[i] == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_CNT_TERM) begin
                    lvl_d     = sync2_q[i];
                    cnt_d     = '0;
                    press_evt = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Debounce counter and level flops.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign press_w[i] = press_evt;
            assign level_w[i] = lvl_q;
        end
    endgenerate

    // Serialize coin presses: emit the highest pending coin, then merge in
    // new events so a set on the bit being cleared wins.
    always_comb begin
        note10_d = pend_q[2];
        note5_d  = pend_q[1] & ~pend_q[2];
        note2_d  = pend_q[0] & ~pend_q[1] & ~pend_q[2];
        pend_d   = pend_q & ~{note10_d, note5_d, note2_d};
        pend_d   = pend_d | press_w[2:0];
        coin_busy_d = |pend_d;
        withdraw_d  = press_w[3];
    end

    // Output and pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            note2_q     <= 1'b0;
            note5_q     <= 1'b0;
            note10_q    <= 1'b0;
            withdraw_q  <= 1'b0;
            coin_busy_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            note2_q     <= note2_d;
            note5_q     <= note5_d;
            note10_q    <= note10_d;
            withdraw_q  <= withdraw_d;
            coin_busy_q <= coin_busy_d;
        end
    end

    assign note2     = note2_q;
    assign note5     = note5_q;
    assign note10    = note10_q;
    assign withdraw  = withdraw_q;
    assign coin_busy = coin_busy_q;
    assign btn_level = level_w;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench for button_conditioner with a
//                behavioural model, directed timing checks and random
//                button activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnl_raw = 1'b0, btnr_raw = 1'b0, btnd_raw = 1'b0, btnc_raw = 1'b0;
    logic       note2, note5, note10, withdraw, coin_busy;
    logic [3:0] btn_level;

    int errors = 0;
    int checks = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnl_raw  (btnl_raw),
        .btnr_raw  (btnr_raw),
        .btnd_raw  (btnd_raw),
        .btnc_raw  (btnc_raw),
        .note2     (note2),
        .note5     (note5),
        .note10    (note10),
        .withdraw  (withdraw),
        .btn_level (btn_level),
        .coin_busy (coin_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each button: the synchronized sample is the raw value two edges old;
    // the level accepts a new value after D consecutive disagreeing samples.
    // Coins: a set of waiting coin values, largest paid out first.
    bit  m_raw_d1[4], m_raw_d2[4];
    bit  m_lvl[4];
    int  m_run[4];
    bit  m_wait10, m_wait5, m_wait2;
    bit  m_n2, m_n5, m_n10, m_wd, m_busy;

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            m_raw_d1[b] = 0; m_raw_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
        end
        m_wait10 = 0; m_wait5 = 0; m_wait2 = 0;
        m_n2 = 0; m_n5 = 0; m_n10 = 0; m_wd = 0; m_busy = 0;
    endtask

    task automatic model_step();
        bit raw[4];
        bit pressed[4];
        raw[0] = btnl_raw; raw[1] = btnr_raw; raw[2] = btnd_raw; raw[3] = btnc_raw;
        for (int b = 0; b < 4; b++) begin
            pressed[b] = 0;
            if (m_raw_d2[b] != m_lvl[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == D) begin
                    m_lvl[b] = m_raw_d2[b];
                    m_run[b] = 0;
                    pressed[b] = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_raw_d2[b] = m_raw_d1[b];
            m_raw_d1[b] = raw[b];
        end
        m_n10 = 0; m_n5 = 0; m_n2 = 0;
        if (m_wait10)     begin m_n10 = 1; m_wait10 = 0; end
        else if (m_wait5) begin m_n5  = 1; m_wait5  = 0; end
        else if (m_wait2) begin m_n2  = 1; m_wait2  = 0; end
        if (pressed[2]) m_wait10 = 1;
        if (pressed[1]) m_wait5  = 1;
        if (pressed[0]) m_wait2  = 1;
        m_busy = m_wait10 | m_wait5 | m_wait2;
        m_wd   = pressed[3];
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else      model_step();
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("outputs{lvl,n10,n5,n2,wd,busy}",
                int'({btn_level, note10, note5, note2, withdraw, coin_busy}),
                int'({m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0], m_n10, m_n5, m_n2, m_wd, m_busy}));
            chk("coin_onehot", int'($countones({note10, note5, note2}) <= 1), 1);
        end
    end

    // ---------------- directed observation helpers ----------------
    // Signal index: 0 note2, 1 note5, 2 note10, 3 withdraw, 4 coin_busy,
    // 5..8 btn_level[0..3]
    int obs_first[9];
    int obs_cnt[9];

    function automatic bit get_sig(input int s);
        case (s)
            0: return note2;
            1: return note5;
            2: return note10;
            3: return withdraw;
            4: return coin_busy;
            5: return btn_level[0];
            6: return btn_level[1];
            7: return btn_level[2];
            default: return btn_level[3];
        endcase
    endfunction

    // First negedge index (1-based) at which each signal is high and the
    // number of high cycles, over a window of win cycles.
    task automatic observe(input int win);
        for (int s = 0; s < 9; s++) begin obs_first[s] = -1; obs_cnt[s] = 0; end
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            for (int s = 0; s < 9; s++) begin
                if (get_sig(s)) begin
                    if (obs_first[s] < 0) obs_first[s] = k;
                    obs_cnt[s]++;
                end
            end
        end
    endtask

    task automatic release_all();
        btnl_raw = 0; btnr_raw = 0; btnd_raw = 0; btnc_raw = 0;
        observe(15);
        chk("no_pulse_on_release", obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3], 0);
    endtask

    int pulses;

    initial begin
        // Reset with all raw inputs high.
        #1 rst = 1'b0;
        btnl_raw = 1; btnr_raw = 1; btnd_raw = 1; btnc_raw = 1;
        observe(4);
        chk("reset_outputs_stay_zero",
            obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3] + obs_cnt[4]
            + obs_cnt[5] + obs_cnt[6] + obs_cnt[7] + obs_cnt[8], 0);
        btnl_raw = 0; btnr_raw = 0; btnd_raw = 0; btnc_raw = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        observe(5);

        // Clean press on L.
        btnl_raw = 1;
        observe(20);
        chk("clean_lvl0_rise", obs_first[5], D + 2);
        chk("clean_note2_first", obs_first[0], D + 3);
        chk("clean_note2_count", obs_cnt[0], 1);
        release_all();

        // Bouncing R.
        pulses = 0;
        btnr_raw = 1; observe(3); pulses += obs_cnt[1];
        btnr_raw = 0; observe(1); pulses += obs_cnt[1];
        btnr_raw = 1; observe(2); pulses += obs_cnt[1];
        btnr_raw = 0; observe(1); pulses += obs_cnt[1];
        btnr_raw = 1; observe(10); pulses += obs_cnt[1];
        chk("bounce_note5_first_after_final_rise", obs_first[1], D + 3);
        chk("bounce_note5_count", pulses, 1);
        release_all();

        // Simultaneous coins.
        btnl_raw = 1; btnr_raw = 1; btnd_raw = 1;
        observe(15);
        chk("simul_note10_first", obs_first[2], D + 3);
        chk("simul_note5_first", obs_first[1], D + 4);
        chk("simul_note2_first", obs_first[0], D + 5);
        chk("simul_pulse_total", obs_cnt[0] + obs_cnt[1] + obs_cnt[2], 3);
        chk("simul_busy_cycles", obs_cnt[4], 3);
        chk("simul_busy_first", obs_first[4], D + 2);
        release_all();

        // Withdraw together with a note10 press.
        btnc_raw = 1; btnd_raw = 1;
        observe(15);
        chk("wd_lvl3_rise", obs_first[8], D + 2);
        chk("wd_first", obs_first[3], D + 2);
        chk("wd_count", obs_cnt[3], 1);
        chk("wd_note10_first", obs_first[2], D + 3);
        chk("wd_note10_count", obs_cnt[2], 1);
        release_all();

        // Reset while the D debounce counter sits at 2.
        btnd_raw = 1;
        observe(4);
        #1 rst = 1'b0;
        observe(3);
        chk("midrst_no_note10_in_reset", obs_cnt[2], 0);
        chk("midrst_lvl_zero_in_reset", obs_cnt[7], 0);
        #1 rst = 1'b1;
        observe(15);
        chk("midrst_note10_after_release", obs_first[2], D + 3);
        chk("midrst_note10_count", obs_cnt[2], 1);
        release_all();

        // Random activity checked by the model; occasional short resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) btnl_raw = ~btnl_raw;
            if ($urandom_range(7) == 0) btnr_raw = ~btnr_raw;
            if ($urandom_range(7) == 0) btnd_raw = ~btnd_raw;
            if ($urandom_range(7) == 0) btnc_raw = ~btnc_raw;
            if ($urandom_range(399) == 0) begin
                #1 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #1 rst = 1'b1;
            end
        end
        btnl_raw = 0; btnr_raw = 0; btnd_raw = 0; btnc_raw = 0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
